// File: rtl/alu_frame_responder.sv
// Byte-stream front end for the 8-bit ALU: collects {op, A, B}, launches the
// ALU, and returns {result, status} over a second valid/ready stream.
module alu_frame_responder #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 8,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        frames_done
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_SEND_RES,
    S_SEND_FLG
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        status_q, status_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        frames_q, frames_d;

  logic in_acc;
  logic out_acc;
  logic op_ok;
  logic to_hit;

  assign in_ready  = (state_q == S_IDLE) ||
                     (state_q == S_GET_A) ||
                     (state_q == S_GET_B);
  assign out_valid = (state_q == S_SEND_RES) ||
                     (state_q == S_SEND_FLG);
  assign busy      = (state_q != S_IDLE);

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  assign op_ok   = (int'(op_q) < NUM_OPS);
  assign to_hit  = (to_cnt_q == TW'(TIMEOUT - 1));

  assign out_data    = out_data_q;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    status_d    = status_q;
    lat_cnt_d   = lat_cnt_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
    frames_d    = frames_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          op_d     = in_data;
          to_cnt_d = '0;
          state_d  = S_GET_A;
        end
      end
      S_GET_A: begin
        if (in_acc) begin
          a_d      = in_data;
          to_cnt_d = '0;
          state_d  = S_GET_B;
        end else if (to_hit) begin
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_GET_B: begin
        if (in_acc) begin
          b_d      = in_data;
          to_cnt_d = '0;
          if (op_ok) begin
            lat_cnt_d = '0;
            state_d   = S_EXEC;
          end else begin
            // Unknown opcode: answer with an error frame, ALU untouched
            out_data_d = '0;
            status_d   = 8'h80;
            state_d    = S_SEND_RES;
          end
        end else if (to_hit) begin
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (lat_cnt_q == LW'(ALU_LAT - 1)) begin
          out_data_d = alu_result;
          status_d   = {4'b0000, alu_flags};
          state_d    = S_SEND_RES;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_SEND_RES: begin
        if (out_acc) begin
          out_data_d = DATA_W'(status_q);
          state_d    = S_SEND_FLG;
        end
      end
      S_SEND_FLG: begin
        if (out_acc) begin
          frames_d = frames_q + 8'd1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      status_q    <= '0;
      lat_cnt_q   <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      status_q    <= status_d;
      lat_cnt_q   <= lat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_alu_frame_responder.sv
// Bench for alu_frame_responder: vector table through a response scoreboard,
// plus sequences for latency, timeout, back-pressure and reset.
module tb_alu_frame_responder;

  localparam int ALU_LAT = 1;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       busy;
  logic       frame_err;
  logic [7:0] frames_done;

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;
  int fd_model = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] stat;
  } vec_t;

  vec_t vecs[$];

  alu_frame_responder #(
    .DATA_W(8), .NUM_OPS(8), .ALU_LAT(ALU_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .frame_err(frame_err), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A
  always_comb begin
    logic [8:0] t;
    logic c, v;
    t = 9'h0;
    c = 1'b0;
    v = 1'b0;
    case (alu_op)
      8'd0: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        c = t[8];
        v = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      8'd1: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        c = t[8];
        v = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      8'd2: t = {1'b0, alu_a & alu_b};
      8'd3: t = {1'b0, alu_a | alu_b};
      8'd4: t = {1'b0, alu_a ^ alu_b};
      default: t = {1'b0, alu_a};
    endcase
    alu_result = t[7:0];
    alu_flags  = {v, c, t[7], (t[7:0] == 8'h00)};
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(out_data), 64'hDEAD);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("resp_byte", 64'(out_data), 64'(e));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input logic [7:0] op, a, b, res, stat);
    exp_q.push_back(res);
    exp_q.push_back(stat);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    wait_drain();
    fd_model = (fd_model + 1) % 256;
    chk("frames_done", 64'(frames_done), 64'(fd_model));
  endtask

  function automatic logic [43:0] rst_vec();
    return {in_ready, out_valid, busy, frame_err,
            out_data, alu_op, alu_a, alu_b, frames_done};
  endfunction

  localparam logic [43:0] RST_EXP = {4'b1000, 40'h0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int e0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", 64'(rst_vec()), 64'(RST_EXP));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_released", 64'(rst_vec()), 64'(RST_EXP));

    vecs.push_back('{8'h00, 8'h05, 8'h03, 8'h08, 8'h00});
    vecs.push_back('{8'h00, 8'hFF, 8'h01, 8'h00, 8'h05});
    vecs.push_back('{8'h00, 8'h7F, 8'h01, 8'h80, 8'h0A});
    vecs.push_back('{8'h01, 8'h05, 8'h03, 8'h02, 8'h00});
    vecs.push_back('{8'h01, 8'h03, 8'h05, 8'hFE, 8'h06});
    vecs.push_back('{8'h02, 8'hF0, 8'h3C, 8'h30, 8'h00});
    vecs.push_back('{8'h02, 8'h0F, 8'hF0, 8'h00, 8'h01});
    vecs.push_back('{8'h03, 8'h50, 8'h0A, 8'h5A, 8'h00});
    vecs.push_back('{8'h04, 8'hAA, 8'hAA, 8'h00, 8'h01});
    vecs.push_back('{8'h07, 8'h00, 8'h99, 8'h00, 8'h01});
    vecs.push_back('{8'h08, 8'h12, 8'h34, 8'h00, 8'h80});
    vecs.push_back('{8'hFF, 8'h56, 8'h78, 8'h00, 8'h80});
    foreach (vecs[i])
      run_frame(vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].stat);

    // ALU latency: out_valid ALU_LAT edges after the B accept edge
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h01);
    chk("exec_in_ready", 64'({in_ready, busy, out_valid}), 64'b010);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("exec_latency", 64'(n), 64'(ALU_LAT));
    wait_drain();
    fd_model++;
    chk("frames_done", 64'(frames_done), 64'(fd_model));

    // Bad opcode skips EXEC; operand regs still capture A/B
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    send_byte(8'h0A);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("badop_no_exec", 64'({out_valid, alu_op, alu_a, alu_b}),
        64'({1'b1, 8'h0A, 8'h11, 8'h22}));
    wait_drain();
    fd_model++;
    chk("frames_done", 64'(frames_done), 64'(fd_model));

    // Timeout abort after op and A
    e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'h77);
    n = 0;
    while (!frame_err && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("timeout_state", 64'({frame_err, busy, in_ready, alu_a}),
        64'({3'b101, 8'h77}));
    @(posedge clk);
    #1;
    chk("frame_err_pulse", 64'({frame_err, busy}), 64'b00);
    chk("frame_err_count", 64'(err_cnt - e0), 64'd1);
    run_frame(8'h00, 8'h05, 8'h03, 8'h08, 8'h00);

    // Byte arriving on the final timeout cycle wins
    e0 = err_cnt;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    send_byte(8'h20);
    wait_drain();
    fd_model++;
    chk("late_byte_no_err", 64'(err_cnt - e0), 64'd0);
    chk("frames_done", 64'(frames_done), 64'(fd_model));

    // Output back-pressure
    out_ready = 1'b0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h02);
    send_byte(8'h04);
    send_byte(8'h0F);
    send_byte(8'hF0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", 64'({out_valid, in_ready, out_data}),
          64'({2'b10, 8'hFF}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
    fd_model++;
    chk("frames_done", 64'(frames_done), 64'(fd_model));

    // Reset in EXEC
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    chk("pre_rst_exec", 64'({busy, in_ready, out_valid}), 64'b100);
    rst = 1'b1;
    #1;
    chk("rst_in_exec", 64'(rst_vec()), 64'(RST_EXP));
    @(posedge clk);
    #1;
    rst = 1'b0;
    fd_model = 0;

    // Reset in SEND_FLG
    out_ready = 1'b0;
    exp_q.push_back(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("send_flg_byte", 64'({out_valid, out_data}), 64'({1'b1, 8'h00}));
    rst = 1'b1;
    #1;
    chk("rst_in_send_flg", 64'(rst_vec()), 64'(RST_EXP));
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    fd_model = 0;

    // 256 frames wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x;
      x = 8'(i);
      run_frame(8'h02, x, 8'hFF, x, {6'b0, x[7], (x == 8'h00)});
    end
    chk("frames_wrap", 64'(frames_done), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
